lpif_link_state_ctrl: RTL and testbench
=======================================

Name: lpif_link_state_ctrl

Overview:
- Sequences the LPIF link-state handshake for the x8 asym2 full slave top.
- Watches the delayed online indications from auto-sync and the received downstream state (dstrm_state/dstrm_valid).
- Drives the upstream state code (ustrm_state/ustrm_valid) and gates user data until both sides agree on ACTIVE.
- Handles settle delay, handshake timeout, retrain, link reset and error hold-off.

Parameters:
- TIMEOUT_W, 16, width of the handshake timeout counter and of timeout_value.
- ERR_HOLD, 64, cycles spent in LINKERR before returning to DOWN (1..65535).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk_wr  in  1  sole clock.
- rst_wr  in  1  asynchronous, active-high reset.
- tx_online_delay  in  1  delayed TX online from auto-sync.
- rx_online_delay  in  1  delayed RX online from auto-sync.
- dstrm_state  in  4  state code received from the link partner.
- dstrm_valid  in  1  qualifies dstrm_state.
- retrain_req  in  1  local retrain request; single-cycle pulse.
- linkreset_req  in  1  local link-reset request; single-cycle pulse.
- settle_value  in  16  cycles to wait after both onlines are high.
- timeout_value  in  TIMEOUT_W  maximum cycles to wait for the partner's state; 0 disables timeout.
- ustrm_state  out  4  state code sent to the partner.
- ustrm_valid  out  1  qualifies ustrm_state.
- link_active  out  1  high only in ACTIVE.
- data_enable  out  1  gates ustrm_dvalid into the datapath.
- err_count  out  ERRCNT_W  number of LINKERR entries.
- ctrl_status  out  32  {err_count padded to 8, 12'h0, fsm_state[3:0], 8'h0}.

Behaviour:
- State codes: RESET=4'h0, ACTIVE=4'h1, LINKRESET=4'h9, RETRAIN=4'hB, LINKERROR=4'hA.
- FSM states: DOWN, SETTLE, REQ_ACT, ACTIVE, RETRAIN, LRESET, LINKERR.
- Reset values: FSM=DOWN, ustrm_state=4'h0, ustrm_valid=0, link_active=0, data_enable=0, err_count=0, all counters=0.
- online = tx_online_delay & rx_online_delay.
- Transitions:
  - DOWN: when online, load settle counter and go to SETTLE.
  - SETTLE: decrement each cycle. On reaching 0, go to REQ_ACT. If settle_value=0, reach REQ_ACT in the next cycle. online drop returns to DOWN.
  - REQ_ACT: ustrm_state=ACTIVE, ustrm_valid=1, timeout counter running.
    - dstrm_valid & dstrm_state==ACTIVE goes to ACTIVE.
    - Timeout expiry (counter == timeout_value, timeout_value!=0) goes to LINKERR.
    - online drop goes to DOWN.
  - ACTIVE: link_active=1, data_enable=1.
    - retrain_req, or dstrm_valid & dstrm_state==RETRAIN, goes to RETRAIN.
    - linkreset_req, or partner LINKRESET, goes to LRESET.
    - Partner LINKERROR goes to LINKERR.
    - online drop goes to DOWN.
  - RETRAIN: ustrm_state=RETRAIN. Wait for partner RETRAIN or ACTIVE, then go to REQ_ACT. Timeout goes to LINKERR.
  - LRESET: ustrm_state=LINKRESET for exactly 2 cycles, then DOWN.
  - LINKERR: ustrm_state=LINKERROR. Hold ERR_HOLD cycles, then DOWN. err_count increments once on entry and saturates at all-ones.
- Priority in any state:
  - online drop > linkreset > partner error > retrain > timeout > normal progress.
  - Exception: LINKERR and LRESET complete their hold regardless of online.
- Latency: all outputs are registered. ustrm_state and link_active reflect a new state 1 cycle after the triggering input is sampled.
- data_enable falls in the same cycle link_active falls; no data beat is enabled outside ACTIVE.
- Timeout counter clears on every state entry and saturates; it never wraps.
- retrain_req is ignored outside ACTIVE. linkreset_req is honoured in every state except LINKERR.
- dstrm_state is ignored when dstrm_valid=0.
- Reset asserted mid-operation forces all reset values asynchronously. Leaving reset starts in DOWN even if online is already high.

Decomposition:
- Package lpif_link_pkg holds:
  - LPIF state-code localparams (RESET, ACTIVE, LINKRESET, RETRAIN, LINKERROR).
  - FSM enum typedef lsm_state_e.
  - ctrl_status field offsets.
- One sub-module, lpif_lsm_timer: loadable down-counter plus saturating up-counter with a terminal flag, reused for settle, timeout and hold.

Test Plan:
- Bring-up: settle_value=5, timeout_value=100; assert both onlines; partner answers ACTIVE at cycle 3 of REQ_ACT -> SETTLE lasts 5 cycles, ustrm_state=4'h1, link_active=1 one cycle after partner ACTIVE is sampled.
- Timeout: timeout_value=20, partner holds RESET -> LINKERR after 20 cycles in REQ_ACT, ustrm_state=4'hA for 64 cycles, err_count=1, then DOWN.
- Retrain: from ACTIVE pulse retrain_req -> ustrm_state=4'hB next cycle and data_enable=0. Partner replies 4'hB -> REQ_ACT -> ACTIVE again.
- Simultaneous events: in ACTIVE, same cycle linkreset_req=1, partner RETRAIN, rx_online_delay=0 -> DOWN (online drop wins), ustrm_valid=0.
- Error saturation with ERRCNT_W=2: force 5 timeouts -> err_count=3, ctrl_status[31:24]=8'h03.
- Async reset asserted mid-LINKERR -> all outputs at reset values in the same cycle; after release FSM is in DOWN and err_count=0.

Source files
------------

// File: rtl/lpif_link_pkg.sv
// -----------------------------------------------------------------------------
// lpif_link_pkg
// Shared definitions for the LPIF link-state controller:
//   - LPIF state codes exchanged with the link partner
//   - link-state machine encoding (lsm_state_e)
//   - ctrl_status field offsets
//   - helpers mapping an FSM state to the upstream code it advertises
// -----------------------------------------------------------------------------
package lpif_link_pkg;

  // LPIF state codes carried on ustrm_state / dstrm_state
  localparam logic [3:0] LPIF_RESET     = 4'h0;
  localparam logic [3:0] LPIF_ACTIVE    = 4'h1;
  localparam logic [3:0] LPIF_LINKRESET = 4'h9;
  localparam logic [3:0] LPIF_LINKERROR = 4'hA;
  localparam logic [3:0] LPIF_RETRAIN   = 4'hB;

  typedef enum logic [3:0] {
    LSM_DOWN    = 4'd0,
    LSM_SETTLE  = 4'd1,
    LSM_REQ_ACT = 4'd2,
    LSM_ACTIVE  = 4'd3,
    LSM_RETRAIN = 4'd4,
    LSM_LRESET  = 4'd5,
    LSM_LINKERR = 4'd6
  } lsm_state_e;

  // ctrl_status layout: {err_count[7:0], 12'h0, fsm_state[3:0], 8'h0}
  localparam int unsigned STAT_ERRCNT_LSB = 24;
  localparam int unsigned STAT_STATE_LSB  = 8;

  // LINKRESET is advertised for a fixed two cycles
  localparam logic [15:0] LRESET_HOLD = 16'd2;

  function automatic logic [3:0] lsm_ustrm_code(input lsm_state_e s);
    case (s)
      LSM_REQ_ACT, LSM_ACTIVE: return LPIF_ACTIVE;
      LSM_RETRAIN:             return LPIF_RETRAIN;
      LSM_LRESET:              return LPIF_LINKRESET;
      LSM_LINKERR:             return LPIF_LINKERROR;
      default:                 return LPIF_RESET;
    endcase
  endfunction

  // Nothing is advertised while the link is down or still settling
  function automatic logic lsm_ustrm_valid(input lsm_state_e s);
    return !(s inside {LSM_DOWN, LSM_SETTLE});
  endfunction

endpackage

// File: rtl/lpif_link_state_ctrl_timer.sv
// -----------------------------------------------------------------------------
// lpif_lsm_timer
// Shared timing resource for the link-state machine:
//   - loadable down-counter (settle, LINKRESET hold, LINKERR hold); stops at 0
//   - saturating up-counter (handshake timeout); never wraps
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_load/i_load_val load the down-counter (otherwise it decrements)
//   i_clr             clear the up-counter (otherwise it increments)
//   i_up_limit        timeout threshold, 0 disables expiry
//   o_down_last       down-counter is in its final cycle (value <= 1)
//   o_up_expire       this cycle is the i_up_limit-th cycle since the clear
// -----------------------------------------------------------------------------
module lpif_lsm_timer #(
  parameter int DOWN_W = 16,
  parameter int UP_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DOWN_W-1:0] i_load_val,
  input  logic              i_clr,
  input  logic [UP_W-1:0]   i_up_limit,
  output logic              o_down_last,
  output logic              o_up_expire
);

  logic [DOWN_W-1:0] r_down;
  logic [UP_W-1:0]   r_up;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_down <= '0;
      r_up   <= '0;
    end else begin
      if (i_load)
        r_down <= i_load_val;
      else if (r_down != '0)
        r_down <= r_down - DOWN_W'(1);

      if (i_clr)
        r_up <= '0;
      else if (r_up != '1)
        r_up <= r_up + UP_W'(1);
    end
  end

  // A loaded value N gives N cycles; 0 and 1 both give a single cycle.
  assign o_down_last = (r_down <= DOWN_W'(1));
  // r_up counts completed cycles, so the limit-th cycle sees limit-1.
  assign o_up_expire = (i_up_limit != '0) && (r_up == i_up_limit - UP_W'(1));

endmodule

// File: rtl/lpif_link_state_ctrl.sv
// -----------------------------------------------------------------------------
// lpif_link_state_ctrl
// LPIF link-state handshake sequencer. Waits for both auto-sync online
// indications, lets them settle, requests ACTIVE from the partner and enables
// user data only once both sides agree. Handles retrain, link reset, handshake
// timeout and a LINKERR hold-off.
// Ports:
//   clk_wr, rst_wr                   clock, asynchronous active-high reset
//   tx/rx_online_delay               delayed online indications
//   dstrm_state/dstrm_valid          state code from the partner
//   retrain_req, linkreset_req       single-cycle local requests
//   settle_value, timeout_value      settle length, handshake timeout (0 = off)
//   ustrm_state/ustrm_valid          state code advertised to the partner
//   link_active, data_enable         high only in ACTIVE
//   err_count                        saturating count of LINKERR entries
//   ctrl_status                      {err_count, 12'h0, fsm_state, 8'h0}
// -----------------------------------------------------------------------------
module lpif_link_state_ctrl
  import lpif_link_pkg::*;
#(
  parameter int          TIMEOUT_W = 16,
  parameter int unsigned ERR_HOLD  = 64,
  parameter int          ERRCNT_W  = 8
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr,
  input  logic                 tx_online_delay,
  input  logic                 rx_online_delay,
  input  logic [3:0]           dstrm_state,
  input  logic                 dstrm_valid,
  input  logic                 retrain_req,
  input  logic                 linkreset_req,
  input  logic [15:0]          settle_value,
  input  logic [TIMEOUT_W-1:0] timeout_value,
  output logic [3:0]           ustrm_state,
  output logic                 ustrm_valid,
  output logic                 link_active,
  output logic                 data_enable,
  output logic [ERRCNT_W-1:0]  err_count,
  output logic [31:0]          ctrl_status
);

  lsm_state_e          r_state;
  lsm_state_e          w_next_state;
  logic [3:0]          r_ustrm_state;
  logic                r_ustrm_valid;
  logic                r_link_active;
  logic                r_data_enable;
  logic [ERRCNT_W-1:0] r_err_count;

  logic        w_online;
  logic        w_p_active, w_p_retrain, w_p_lreset, w_p_error;
  logic        w_entry;
  logic [15:0] w_load_val;
  logic        w_down_last;
  logic        w_up_expire;

  assign w_online    = tx_online_delay & rx_online_delay;
  // Partner codes only count while qualified
  assign w_p_active  = dstrm_valid && (dstrm_state == LPIF_ACTIVE);
  assign w_p_retrain = dstrm_valid && (dstrm_state == LPIF_RETRAIN);
  assign w_p_lreset  = dstrm_valid && (dstrm_state == LPIF_LINKRESET);
  assign w_p_error   = dstrm_valid && (dstrm_state == LPIF_LINKERROR);

  // Priority: online drop > link reset > partner error > retrain > timeout >
  // normal progress. LRESET and LINKERR always run their hold to completion.
  // NOTE: w_next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LSM_DOWN: begin
        if (w_online) w_next_state = linkreset_req ? LSM_LRESET : LSM_SETTLE;
      end
      LSM_SETTLE: begin
        if (!w_online)         w_next_state = LSM_DOWN;
        else if (linkreset_req) w_next_state = LSM_LRESET;
        else if (w_p_error)     w_next_state = LSM_LINKERR;
        else if (w_down_last)   w_next_state = LSM_REQ_ACT;
      end
      LSM_REQ_ACT: begin
        if (!w_online)         w_next_state = LSM_DOWN;
        else if (linkreset_req) w_next_state = LSM_LRESET;
        else if (w_p_error)     w_next_state = LSM_LINKERR;
        else if (w_up_expire)   w_next_state = LSM_LINKERR;
        else if (w_p_active)    w_next_state = LSM_ACTIVE;
      end
      LSM_ACTIVE: begin
        if (!w_online)                       w_next_state = LSM_DOWN;
        else if (linkreset_req || w_p_lreset) w_next_state = LSM_LRESET;
        else if (w_p_error)                   w_next_state = LSM_LINKERR;
        else if (retrain_req || w_p_retrain)  w_next_state = LSM_RETRAIN;
      end
      LSM_RETRAIN: begin
        if (!w_online)                      w_next_state = LSM_DOWN;
        else if (linkreset_req)              w_next_state = LSM_LRESET;
        else if (w_p_error)                  w_next_state = LSM_LINKERR;
        else if (w_up_expire)                w_next_state = LSM_LINKERR;
        else if (w_p_retrain || w_p_active)  w_next_state = LSM_REQ_ACT;
      end
      LSM_LRESET, LSM_LINKERR: begin
        if (w_down_last) w_next_state = LSM_DOWN;
      end
      default: w_next_state = LSM_DOWN;
    endcase
  end

  // Every state entry reloads the down-counter and clears the timeout counter
  assign w_entry = (w_next_state != r_state);

  always_comb begin
    w_load_val = '0;
    case (w_next_state)
      LSM_SETTLE:  w_load_val = settle_value;
      LSM_LRESET:  w_load_val = LRESET_HOLD;
      LSM_LINKERR: w_load_val = 16'(ERR_HOLD);
      default:     w_load_val = '0;
    endcase
  end

  lpif_lsm_timer #(
    .DOWN_W (16),
    .UP_W   (TIMEOUT_W)
  ) u_timer (
    .i_clk       (clk_wr),
    .i_rst       (rst_wr),
    .i_load      (w_entry),
    .i_load_val  (w_load_val),
    .i_clr       (w_entry),
    .i_up_limit  (timeout_value),
    .o_down_last (w_down_last),
    .o_up_expire (w_up_expire)
  );

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_state       <= LSM_DOWN;
      r_ustrm_state <= LPIF_RESET;
      r_ustrm_valid <= 1'b0;
      r_link_active <= 1'b0;
      r_data_enable <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_next_state;
      r_ustrm_state <= lsm_ustrm_code(w_next_state);
      r_ustrm_valid <= lsm_ustrm_valid(w_next_state);
      r_link_active <= (w_next_state == LSM_ACTIVE);
      r_data_enable <= (w_next_state == LSM_ACTIVE);
      if (w_entry && (w_next_state == LSM_LINKERR) && (r_err_count != '1))
        r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

  assign ustrm_state = r_ustrm_state;
  assign ustrm_valid = r_ustrm_valid;
  assign link_active = r_link_active;
  assign data_enable = r_data_enable;
  assign err_count   = r_err_count;

  always_comb begin
    ctrl_status = '0;
    ctrl_status[STAT_ERRCNT_LSB +: 8] = 8'(r_err_count);
    ctrl_status[STAT_STATE_LSB  +: 4] = r_state;
  end

endmodule

// File: tb/tb_lpif_link_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lpif_link_state_ctrl
// Directed bench: a per-cycle vector table for bring-up, retrain and
// simultaneous events, then hand sequences for timeout/LINKERR hold, error
// counter saturation (second instance with ERRCNT_W=2) and async reset.
// -----------------------------------------------------------------------------
module tb_lpif_link_state_ctrl;

  logic        clk_wr = 1'b0;
  logic        rst_wr = 1'b1;
  logic        tx_online_delay = 1'b0;
  logic        rx_online_delay = 1'b0;
  logic [3:0]  dstrm_state = 4'h0;
  logic        dstrm_valid = 1'b0;
  logic        retrain_req = 1'b0;
  logic        linkreset_req = 1'b0;
  logic [15:0] settle_value = 16'd5;
  logic [15:0] timeout_value = 16'd100;

  logic [3:0]  ustrm_state, s_ustrm_state;
  logic        ustrm_valid, s_ustrm_valid;
  logic        link_active, s_link_active;
  logic        data_enable, s_data_enable;
  logic [7:0]  err_count;
  logic [1:0]  s_err_count;
  logic [31:0] ctrl_status, s_ctrl_status;

  int checks = 0;
  int errors = 0;

  always #5 clk_wr = ~clk_wr;

  lpif_link_state_ctrl u_dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr),
    .tx_online_delay(tx_online_delay), .rx_online_delay(rx_online_delay),
    .dstrm_state(dstrm_state), .dstrm_valid(dstrm_valid),
    .retrain_req(retrain_req), .linkreset_req(linkreset_req),
    .settle_value(settle_value), .timeout_value(timeout_value),
    .ustrm_state(ustrm_state), .ustrm_valid(ustrm_valid),
    .link_active(link_active), .data_enable(data_enable),
    .err_count(err_count), .ctrl_status(ctrl_status)
  );

  lpif_link_state_ctrl #(.ERRCNT_W(2)) u_dut_sat (
    .clk_wr(clk_wr), .rst_wr(rst_wr),
    .tx_online_delay(tx_online_delay), .rx_online_delay(rx_online_delay),
    .dstrm_state(dstrm_state), .dstrm_valid(dstrm_valid),
    .retrain_req(retrain_req), .linkreset_req(linkreset_req),
    .settle_value(settle_value), .timeout_value(timeout_value),
    .ustrm_state(s_ustrm_state), .ustrm_valid(s_ustrm_valid),
    .link_active(s_link_active), .data_enable(s_data_enable),
    .err_count(s_err_count), .ctrl_status(s_ctrl_status)
  );

  typedef struct {
    logic       tx, rx;
    logic [3:0] ds;
    logic       dv, rt, lr;
    logic [3:0] e_us;
    logic       e_uv, e_la, e_de;
    logic [3:0] e_fsm;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic tx, input logic rx, input logic [3:0] ds,
                              input logic dv, input logic rt, input logic lr,
                              input logic [3:0] e_us, input logic e_uv,
                              input logic e_la, input logic [3:0] e_fsm);
    vec_t v;
    v.tx = tx; v.rx = rx; v.ds = ds; v.dv = dv; v.rt = rt; v.lr = lr;
    v.e_us = e_us; v.e_uv = e_uv; v.e_la = e_la; v.e_de = e_la; v.e_fsm = e_fsm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  function automatic logic [3:0] fsm();
    return ctrl_status[11:8];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int exp_sat;

    // Bring-up, retrain, simultaneous events, link reset (settle 5, timeout 100)
    //               tx rx ds    dv rt lr  us    uv la fsm
    vecs[0]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'd1);
    vecs[1]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'd1);
    vecs[2]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'd1);
    vecs[3]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'd1);
    vecs[4]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'd1);
    vecs[5]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h1, 1, 0, 4'd2);
    vecs[6]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h1, 1, 0, 4'd2);
    vecs[7]  = mk(1, 1, 4'h0, 0, 0, 0, 4'h1, 1, 0, 4'd2);
    vecs[8]  = mk(1, 1, 4'h1, 1, 0, 0, 4'h1, 1, 1, 4'd3);
    vecs[9]  = mk(1, 1, 4'h1, 1, 0, 0, 4'h1, 1, 1, 4'd3);
    vecs[10] = mk(1, 1, 4'h1, 1, 1, 0, 4'hB, 1, 0, 4'd4);
    vecs[11] = mk(1, 1, 4'h1, 0, 0, 0, 4'hB, 1, 0, 4'd4);
    vecs[12] = mk(1, 1, 4'hB, 1, 0, 0, 4'h1, 1, 0, 4'd2);
    vecs[13] = mk(1, 1, 4'h1, 1, 0, 0, 4'h1, 1, 1, 4'd3);
    vecs[14] = mk(1, 1, 4'h0, 0, 0, 0, 4'h1, 1, 1, 4'd3);
    vecs[15] = mk(1, 1, 4'h9, 0, 0, 0, 4'h1, 1, 1, 4'd3);
    vecs[16] = mk(1, 0, 4'hB, 1, 0, 1, 4'h0, 0, 0, 4'd0);
    vecs[17] = mk(1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'd1);
    vecs[18] = mk(1, 1, 4'h0, 0, 0, 1, 4'h9, 1, 0, 4'd5);
    vecs[19] = mk(1, 0, 4'h0, 0, 0, 0, 4'h9, 1, 0, 4'd5);
    vecs[20] = mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'd0);

    // Reset state
    #12;
    check("rst_ustrm_state", ustrm_state, 4'h0);
    check("rst_ustrm_valid", ustrm_valid, 1'b0);
    check("rst_link_active", link_active, 1'b0);
    check("rst_data_enable", data_enable, 1'b0);
    check("rst_err_count", err_count, 8'h0);
    check("rst_ctrl_status", ctrl_status, 32'h0);
    @(negedge clk_wr);
    rst_wr = 1'b0;
    tick();

    for (int i = 0; i < 21; i++) begin
      tx_online_delay = vecs[i].tx;
      rx_online_delay = vecs[i].rx;
      dstrm_state     = vecs[i].ds;
      dstrm_valid     = vecs[i].dv;
      retrain_req     = vecs[i].rt;
      linkreset_req   = vecs[i].lr;
      tick();
      check($sformatf("v%0d_ustrm_state", i), ustrm_state, vecs[i].e_us);
      check($sformatf("v%0d_ustrm_valid", i), ustrm_valid, vecs[i].e_uv);
      check($sformatf("v%0d_link_active", i), link_active, vecs[i].e_la);
      check($sformatf("v%0d_data_enable", i), data_enable, vecs[i].e_de);
      check($sformatf("v%0d_ctrl_status", i), ctrl_status, {16'h0, vecs[i].e_fsm, 8'h0});
    end

    // Timeout rounds: partner holds RESET, 20-cycle timeout, 64-cycle hold
    retrain_req = 1'b0; linkreset_req = 1'b0;
    dstrm_state = 4'h0; dstrm_valid = 1'b1;
    timeout_value = 16'd20;
    tx_online_delay = 1'b1; rx_online_delay = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      n = 0;
      while (fsm() != 4'd2 && n < 50) begin tick(); n++; end
      check($sformatf("r%0d_reach_req_act", r), fsm(), 4'd2);
      n = 1; tick();
      while (fsm() == 4'd2 && n < 200) begin n++; tick(); end
      check($sformatf("r%0d_req_act_cycles", r), n, 20);
      check($sformatf("r%0d_enter_linkerr", r), fsm(), 4'd6);
      check($sformatf("r%0d_linkerr_code", r), ustrm_state, 4'hA);
      n = 1; bad = 0; tick();
      while (fsm() == 4'd6 && n < 200) begin
        if (ustrm_state !== 4'hA || link_active !== 1'b0) bad++;
        n++; tick();
      end
      check($sformatf("r%0d_linkerr_cycles", r), n, 64);
      check($sformatf("r%0d_linkerr_hold_outputs", r), bad, 0);
      check($sformatf("r%0d_back_to_down", r), fsm(), 4'd0);
      check($sformatf("r%0d_err_count", r), err_count, r);
      exp_sat = (r > 3) ? 3 : r;
      check($sformatf("r%0d_err_count_sat", r), s_err_count, exp_sat);
    end
    check("sat_ctrl_status_err", s_ctrl_status[31:24], 8'h03);
    check("wide_ctrl_status_err", ctrl_status[31:24], 8'h05);

    // Async reset in the middle of LINKERR
    n = 0;
    while (fsm() != 4'd6 && n < 200) begin tick(); n++; end
    check("reach_linkerr_again", fsm(), 4'd6);
    tick(); tick(); tick();
    #2 rst_wr = 1'b1;
    #1;
    check("arst_ustrm_state", ustrm_state, 4'h0);
    check("arst_ustrm_valid", ustrm_valid, 1'b0);
    check("arst_link_active", link_active, 1'b0);
    check("arst_data_enable", data_enable, 1'b0);
    check("arst_ctrl_status", ctrl_status, 32'h0);
    check("arst_err_count_sat", s_err_count, 2'd0);
    settle_value = 16'd0;
    repeat (2) @(posedge clk_wr);
    @(negedge clk_wr);
    rst_wr = 1'b0;
    #1;
    check("post_rst_down", ctrl_status, 32'h0);
    // Online already high: DOWN -> SETTLE, then settle_value=0 gives REQ_ACT
    tick();
    check("post_rst_settle", fsm(), 4'd1);
    tick();
    check("settle0_req_act", fsm(), 4'd2);
    check("settle0_ustrm_state", ustrm_state, 4'h1);
    check("settle0_ustrm_valid", ustrm_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
